sysid_regs_avs: RTL
===================

Name: sysid_regs_avs

Overview:
- Parametrised system-ID slave on the Avalon-MM bus; next generation of the fixed ID/timestamp ROM slave.
- Fixed read latency of 1 cycle with readdatavalid.
- Adds a capability word and a 64-bit uptime counter with a tear-free high-word snapshot.
- Adds a control register and NUM_SCRATCH byte-writable scratch registers for software bring-up and sanity checks.

Parameters:
- SYSTEM_ID, 32'h5A5A0001, value returned at word 0.
- TIMESTAMP, 32'd0, build timestamp returned at word 1.
- VERSION, 16'h0002, block version, reported in the CAPS word.
- NUM_SCRATCH, 2, number of scratch registers, range 0..8.
- ADDR_W, 4, word-address width. Elaboration must fail unless 6+NUM_SCRATCH <= 2**ADDR_W.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, single cycle per access.
- write  in  1  write strobe, single cycle per access.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for write.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for exactly 1 cycle, the cycle after an accepted read.

Behaviour:
- Reset: when reset_n=0 at a clock edge, the following clear:
  - readdata=0, readdatavalid=0
  - uptime=0, hi_snap=0
  - CONTROL.EN=1
  - all scratch registers=0
- Reset mid-read: the pending readdatavalid is suppressed.
- No waitrequest. Every read and write is accepted in the cycle it is presented.
- Read latency is exactly 1. readdata updates only on an accepted read and otherwise holds its value. readdatavalid=0 when no read is presented.
- Register map (word addresses):
  - 0 SYSTEM_ID: RO.
  - 1 TIMESTAMP: RO.
  - 2 CAPS: RO, {VERSION[15:0], NUM_SCRATCH[7:0], ADDR_W[7:0]}.
  - 3 UPTIME_LO: RO. Returns uptime[31:0] as of the read cycle. In the same cycle, hi_snap <= uptime[63:32].
  - 4 UPTIME_HI: RO. Returns hi_snap, not the live high word.
  - 5 CONTROL: RW.
    - bit0 EN: counter enable.
    - bit1 CLR: write-1 clears the counter. Self-clearing; reads as 0.
    - bits 31:2 read 0.
  - 6..6+NUM_SCRATCH-1 SCRATCHn: RW, per-byte write via byteenable.
  - All other addresses: read 0, writes ignored.
- Writes to RO registers are ignored.
- A byteenable=0 write changes nothing.
- CONTROL writes honour byteenable[0] only.
- Uptime counter:
  - 64-bit; +1 per clock when EN=1.
  - Wraps 2^64-1 -> 0 with no flag.
  - Priority: CLR write > increment. The counter is 0 the cycle after a CLR write, regardless of EN.
  - An EN=0 write freezes the counter from the next cycle.
- Simultaneous read and write in the same cycle: the read is serviced and the write is dropped, including its side effects (no CLR, no scratch update).
- UPTIME_LO read in the same cycle the counter wraps:
  - LO returns 32'hFFFFFFFF.
  - hi_snap takes the pre-increment high word.
  - LO and hi_snap are therefore consistent.
- Address compare uses the full ADDR_W bits; no aliasing.

Decomposition:
- Package sysid_regs_pkg holds:
  - register word-address localparams: ADDR_SYSID=0, ADDR_TS=1, ADDR_CAPS=2, ADDR_UPLO=3, ADDR_UPHI=4, ADDR_CTRL=5, ADDR_SCR0=6
  - CONTROL bit indices EN_BIT=0, CLR_BIT=1
- One sub-module, sysid_uptime_ctr:
  - Contents: 64-bit counter with enable, synchronous clear, and hi-snapshot capture.
  - Ports: clock, reset_n, en, clr, snap, count[63:0], hi_snap[31:0].
- The top level contains address decode, the scratch array and the read mux register.

Test Plan:
- Reset, then read addresses 0, 1, 2 (defaults) -> readdata 32'h5A5A0001, 0, 32'h00020204, each with readdatavalid high exactly 1 cycle after read.
- Write SCRATCH0=32'hDEADBEEF with byteenable=4'hF, then a write of 32'h00000011 with byteenable=4'b0001, then read -> 32'hDEADBE11. Read address 15 -> 0. Write to address 0, then read it -> still 32'h5A5A0001.
- Force uptime to 64'h0000_0001_FFFF_FFFF via CLR plus a backdoor preload, then read UPTIME_LO in the wrap cycle -> 32'hFFFFFFFF. A following UPTIME_HI read -> 32'h00000001, not 2.
- Write CONTROL=0, wait 10 cycles, read UPTIME_LO twice -> identical values. Write CONTROL=1 -> values increase by the cycle delta.
- Write CONTROL=3 (CLR with EN=1), read UPTIME_LO 3 cycles later -> 2. Read CONTROL -> 1.
- read and write asserted together on SCRATCH1 with writedata=5 -> readdata returns the old value 0, and a subsequent read is still 0. Assert reset_n=0 in the cycle after a read -> readdatavalid=0 and readdata=0.

Source files
------------

// File: rtl/sysid_regs_pkg.sv
// Shared definitions for the system-ID register slave: word map, CONTROL
// bit positions, register-select encoding and small data helpers.
package sysid_regs_pkg;

    localparam int ADDR_SYSID = 0;
    localparam int ADDR_TS    = 1;
    localparam int ADDR_CAPS  = 2;
    localparam int ADDR_UPLO  = 3;
    localparam int ADDR_UPHI  = 4;
    localparam int ADDR_CTRL  = 5;
    localparam int ADDR_SCR0  = 6;

    localparam int EN_BIT  = 0;
    localparam int CLR_BIT = 1;

    localparam int MAX_SCRATCH = 8;

    typedef enum logic [2:0] {
        REG_SYSID,
        REG_TS,
        REG_CAPS,
        REG_UPLO,
        REG_UPHI,
        REG_CTRL,
        REG_SCR,
        REG_NONE
    } reg_sel_e;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] caps_word(
        input logic [15:0] version,
        input int          num_scratch,
        input int          addr_w
    );
        return {version, 8'(num_scratch), 8'(addr_w)};
    endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// 64-bit free-running uptime counter with enable, synchronous clear and a
// capture of the high word taken alongside a low-word read.
module sysid_uptime_ctr (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        en,
    input  logic        clr,
    input  logic        snap,
    output logic [63:0] count,
    output logic [31:0] hi_snap
);

    logic [63:0] count_q;
    logic [63:0] count_d;
    logic [31:0] hi_snap_q;
    logic [31:0] hi_snap_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 64'd1;
        end
    end

    // Snapshot the pre-increment high word so it always pairs with the low
    // word returned in the same cycle, even across a 32-bit carry.
    always_comb begin
        hi_snap_d = hi_snap_q;
        if (snap) begin
            hi_snap_d = count_q[63:32];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q   <= '0;
            hi_snap_q <= '0;
        end else begin
            count_q   <= count_d;
            hi_snap_q <= hi_snap_d;
        end
    end

    assign count   = count_q;
    assign hi_snap = hi_snap_q;

endmodule

// File: rtl/sysid_regs_avs.sv
// Avalon-MM system-ID slave: ID/timestamp/caps words, uptime counter,
// CONTROL register and byte-writable scratch registers, 1-cycle read latency.
module sysid_regs_avs
    import sysid_regs_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID   = 32'h5A5A0001,
    parameter logic [31:0] TIMESTAMP   = 32'd0,
    parameter logic [15:0] VERSION     = 16'h0002,
    parameter int          NUM_SCRATCH = 2,
    parameter int          ADDR_W      = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    generate
        if (NUM_SCRATCH < 0 || NUM_SCRATCH > MAX_SCRATCH) begin : g_bad_num_scratch
            $error("sysid_regs_avs: NUM_SCRATCH must be in 0..8");
        end
        if (ADDR_SCR0 + NUM_SCRATCH > (1 << ADDR_W)) begin : g_bad_addr_w
            $error("sysid_regs_avs: ADDR_W too small for the register map");
        end
    endgenerate

    localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

    logic                      rd_acc;
    logic                      wr_acc;
    reg_sel_e                  reg_sel;
    logic [SCR_N-1:0]          scr_hit;

    logic                      en_q;
    logic                      en_d;
    logic                      ctrl_clr;

    logic [SCR_N-1:0][31:0]    scratch_q;
    logic [SCR_N-1:0][31:0]    scratch_d;

    logic [31:0]               rd_word;
    logic [31:0]               readdata_q;
    logic [31:0]               readdata_d;
    logic                      readdatavalid_q;
    logic                      readdatavalid_d;

    logic [63:0]               uptime;
    logic [31:0]               hi_snap;
    logic                      unused_uptime_hi;

    // A read wins over a write presented in the same cycle; the write is
    // dropped entirely, side effects included.
    assign rd_acc = read;
    assign wr_acc = write && !read;

    generate
        if (NUM_SCRATCH == 0) begin : g_no_scr
            assign scr_hit = '0;
        end else begin : g_scr
            for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_hit
                assign scr_hit[gi] = (address == ADDR_W'(ADDR_SCR0 + gi));
            end
        end
    endgenerate

    always_comb begin
        reg_sel = REG_NONE;
        if (address == ADDR_W'(ADDR_SYSID)) begin
            reg_sel = REG_SYSID;
        end else if (address == ADDR_W'(ADDR_TS)) begin
            reg_sel = REG_TS;
        end else if (address == ADDR_W'(ADDR_CAPS)) begin
            reg_sel = REG_CAPS;
        end else if (address == ADDR_W'(ADDR_UPLO)) begin
            reg_sel = REG_UPLO;
        end else if (address == ADDR_W'(ADDR_UPHI)) begin
            reg_sel = REG_UPHI;
        end else if (address == ADDR_W'(ADDR_CTRL)) begin
            reg_sel = REG_CTRL;
        end else if (|scr_hit) begin
            reg_sel = REG_SCR;
        end
    end

    // CONTROL lives entirely in byte lane 0; CLR is a pulse, never stored.
    always_comb begin
        en_d     = en_q;
        ctrl_clr = 1'b0;
        if (wr_acc && reg_sel == REG_CTRL && byteenable[0]) begin
            en_d     = writedata[EN_BIT];
            ctrl_clr = writedata[CLR_BIT];
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (wr_acc && scr_hit[i]) begin
                scratch_d[i] = byte_merge(scratch_q[i], writedata, byteenable);
            end
        end
    end

    sysid_uptime_ctr u_uptime (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (en_q),
        .clr     (ctrl_clr),
        .snap    (rd_acc && reg_sel == REG_UPLO),
        .count   (uptime),
        .hi_snap (hi_snap)
    );

    // The live high word is only ever exposed through hi_snap.
    assign unused_uptime_hi = ^uptime[63:32];

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_SYSID: rd_word = SYSTEM_ID;
            REG_TS:    rd_word = TIMESTAMP;
            REG_CAPS:  rd_word = caps_word(VERSION, NUM_SCRATCH, ADDR_W);
            REG_UPLO:  rd_word = uptime[31:0];
            REG_UPHI:  rd_word = hi_snap;
            REG_CTRL:  rd_word[EN_BIT] = en_q;
            REG_SCR: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (scr_hit[i]) begin
                        rd_word = scratch_q[i];
                    end
                end
            end
            default:   rd_word = '0;
        endcase
    end

    always_comb begin
        readdata_d      = readdata_q;
        readdatavalid_d = rd_acc;
        if (rd_acc) begin
            readdata_d = rd_word;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            en_q            <= 1'b1;
            scratch_q       <= '0;
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
            en_q            <= en_d;
            scratch_q       <= scratch_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule
